// File: rtl/shift_serial.sv
// -----------------------------------------------------------------------------
// shift_serial
//   Multi-cycle shift unit: sequential counterpart of the single-cycle barrel
//   shifter, same op encoding (00/10 = SLL, 01 = SRL, 11 = SRA). A request is
//   accepted from IDLE or DONE, the operand shifts one bit per clock, and a
//   one-cycle done pulse marks a valid result. out holds until the next
//   request completes or reset.
//
//   Optional build macro: SHIFT_SERIAL_NIBBLE_EN
//     When defined, SHIFT steps by 4 bits while the remaining count is >= 4,
//     reducing latency; results are bit-identical to the default build.
//
// Ports:
//   clk     in   1   rising-edge clock
//   reset   in   1   synchronous, active-high reset (priority over start)
//   start   in   1   request strobe, ignored while busy
//   in      in  32   operand, latched on accept
//   amount  in   5   shift distance 0..31, latched on accept
//   op      in   2   operation, latched on accept
//   busy    out  1   high while shifting
//   done    out  1   one-cycle result-valid pulse
//   out     out 32   result, held until next completion
// -----------------------------------------------------------------------------
module shift_serial (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in,
    input  logic [4:0]  amount,
    input  logic [1:0]  op,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AMT_W  = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_sh;
    logic [DATA_W-1:0]   w_sh_nxt;
    logic [DATA_W-1:0]   w_sh_step;
    logic [DATA_W-1:0]   r_out;
    logic [DATA_W-1:0]   w_out_nxt;
    logic [AMT_W-1:0]    r_cnt;
    logic [AMT_W-1:0]    w_cnt_nxt;
    logic [AMT_W-1:0]    w_dec;
    logic [1:0]          r_op;
    logic [1:0]          w_op_nxt;
    logic                r_busy;
    logic                r_done;
    logic                w_accept;
    logic                w_nib;
    logic                w_last;
    logic                w_right;
    logic                w_fill;

    // A new request may be taken whenever no shift is in flight.
    assign w_accept = start && (r_state != S_SHIFT);

    // Step size selection: 4-bit steps only in the nibble build.
`ifdef SHIFT_SERIAL_NIBBLE_EN
    assign w_nib = (r_cnt >= AMT_W'(4));
`else
    assign w_nib = 1'b0;
`endif

    // Final step: a nibble step that exactly consumes count=4, or a unit step at count=1.
    assign w_last  = w_nib ? (r_cnt == AMT_W'(4)) : (r_cnt == AMT_W'(1));
    assign w_dec   = w_nib ? AMT_W'(4) : AMT_W'(1);

    // op[0] selects right shifts; SRA replicates the held sign bit, which
    // stays equal to the original in[31] for the whole operation.
    assign w_right = r_op[0];
    assign w_fill  = (r_op == 2'b11) && r_sh[DATA_W-1];

    // One shift step of the working register.
    always_comb begin
        w_sh_step = r_sh;
        if (w_nib) begin
            w_sh_step = w_right ? {{4{w_fill}}, r_sh[DATA_W-1:4]}
                                : {r_sh[DATA_W-5:0], 4'b0000};
        end else begin
            w_sh_step = w_right ? {w_fill, r_sh[DATA_W-1:1]}
                                : {r_sh[DATA_W-2:0], 1'b0};
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_out_nxt   = r_out;

        case (r_state)
            S_SHIFT: begin
                w_sh_nxt  = w_sh_step;
                w_cnt_nxt = r_cnt - w_dec;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                    w_out_nxt   = w_sh_step;
                end
            end
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_sh_nxt  = in;
                    w_cnt_nxt = amount;
                    w_op_nxt  = op;
                    if (amount == AMT_W'(0)) begin
                        w_state_nxt = S_DONE;
                        w_out_nxt   = in;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; busy/done registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_out   <= w_out_nxt;
            r_busy  <= (w_state_nxt == S_SHIFT);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign out  = r_out;

`ifdef FORMAL
    // Shadow copy of the accepted request for result checking.
    logic [DATA_W-1:0] r_f_in;
    logic [AMT_W-1:0]  r_f_amt;
    logic [DATA_W-1:0] w_f_ref;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_f_in  <= '0;
            r_f_amt <= '0;
        end else if (w_accept) begin
            r_f_in  <= in;
            r_f_amt <= amount;
        end
    end

    always_comb begin
        case (r_op)
            2'b01:   w_f_ref = r_f_in >> r_f_amt;
            2'b11:   w_f_ref = DATA_W'($signed(r_f_in) >>> r_f_amt);
            default: w_f_ref = r_f_in << r_f_amt;
        endcase
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(r_busy && r_done));
            if (r_done) assert (r_out == w_f_ref);
        end
    end
`endif

endmodule

// File: tb/tb_shift_serial.sv
// -----------------------------------------------------------------------------
// tb_shift_serial
//   Self-checking bench for shift_serial. A cycle-level reference model tracks
//   each accepted request as an accept cycle plus a completion cycle and the
//   arithmetic result; DUT busy/done/out are compared every cycle.
// -----------------------------------------------------------------------------
module tb_shift_serial;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] t_in;
    logic [4:0]  t_amt;
    logic [1:0]  t_op;
    logic        busy;
    logic        done;
    logic [31:0] t_out;

    shift_serial dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in     (t_in),
        .amount (t_amt),
        .op     (t_op),
        .busy   (busy),
        .done   (done),
        .out    (t_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          cyc      = 0;
    int          m_done   = 0;
    bit          m_active = 1'b0;
    logic [31:0] m_out    = '0;
    logic [31:0] m_new    = '0;

    typedef struct {
        logic [31:0] din;
        logic [4:0]  amt;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a,
                                              input logic [1:0] o);
        case (o)
            2'b01:   return d >> a;
            2'b11:   return 32'($signed(d) >>> a);
            default: return d << a;
        endcase
    endfunction

    // Cycles spent in SHIFT for a given amount.
    function automatic int lat_of(input logic [4:0] a);
`ifdef SHIFT_SERIAL_NIBBLE_EN
        return int'(a) / 4 + int'(a) % 4;
`else
        return int'(a);
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance model.
    task automatic step(input logic st, input logic [31:0] d, input logic [4:0] a,
                        input logic [1:0] o, input logic rs);
        logic be;
        logic de;
        @(negedge clk);
        if (m_active && cyc == m_done) m_out = m_new;
        be = m_active && (cyc < m_done);
        de = m_active && (cyc == m_done);
        chk("busy", 32'(busy), 32'(be));
        chk("done", 32'(done), 32'(de));
        chk("out", t_out, m_out);
        start = st;
        t_in  = d;
        t_amt = a;
        t_op  = o;
        reset = rs;
        if (rs) begin
            m_active = 1'b0;
            m_out    = '0;
        end else if (st && !be) begin
            m_active = 1'b1;
            m_done   = cyc + 1 + lat_of(a);
            m_new    = ref_shift(d, a, o);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 5'd0, 2'b00, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0001, 5'd5,  2'b00, 32'h0000_0020};
        vecs[1]  = '{32'h8000_0000, 5'd31, 2'b11, 32'hFFFF_FFFF};
        vecs[2]  = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001};
        vecs[3]  = '{32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF};
        vecs[4]  = '{32'hDEAD_BEEF, 5'd4,  2'b10, 32'hEADB_EEF0};
        vecs[5]  = '{32'hF000_0000, 5'd4,  2'b11, 32'hFF00_0000};
        vecs[6]  = '{32'h1234_5678, 5'd7,  2'b01, 32'h0024_68AC};
        vecs[7]  = '{32'h8000_0001, 5'd1,  2'b11, 32'hC000_0000};
        vecs[8]  = '{32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000};
        vecs[9]  = '{32'h7FFF_FFFF, 5'd30, 2'b11, 32'h0000_0001};
        vecs[10] = '{32'hA5A5_A5A5, 5'd9,  2'b11, 32'hFFD2_D2D2};

        reset = 1'b1;
        start = 1'b0;
        t_in  = '0;
        t_amt = '0;
        t_op  = '0;
        repeat (2) @(posedge clk);
        // Reset state check happens on the first step; reset still held for it.
        step(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
        idle(2);

        // Table-driven single requests
        for (int v = 0; v < 11; v++) begin
            step(1'b1, vecs[v].din, vecs[v].amt, vecs[v].op, 1'b0);
            idle(lat_of(vecs[v].amt) + 1);
            chk($sformatf("vec%0d_out", v), t_out, vecs[v].exp);
            idle(1);
        end

        // Start held high through a 3-bit SRL; accepted again in the DONE cycle
        step(1'b1, 32'h0000_0F00, 5'd3, 2'b01, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 32'hFFFF_FFFF, 5'd7, 2'b11, 1'b0);
        step(1'b1, 32'h0000_0001, 5'd1, 2'b00, 1'b0);
        chk("overlap_first", t_out, 32'h0000_01E0);
        idle(2);
        chk("overlap_second", t_out, 32'h0000_0002);
        idle(2);

        // Reset mid-shift discards the request, then a new one completes
        step(1'b1, 32'h0000_0003, 5'd20, 2'b00, 1'b0);
        idle(6);
        step(1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
        idle(25);
        chk("post_reset_out", t_out, 32'h0000_0000);
        step(1'b1, 32'h0000_00F0, 5'd2, 2'b01, 1'b0);
        idle(3);
        chk("after_reset_req", t_out, 32'h0000_003C);

        // Randomized traffic with occasional reset
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                 $urandom,
                 5'($urandom_range(0, 31)),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_serial.md
Name: shift_serial

Overview:
Multi-cycle, low-area shift unit for the execute stage. It is the sequential counterpart of the core's single-cycle barrel shifter and uses the same operation encoding. A request is accepted with a start pulse, the operand is shifted one bit per clock, and completion is signalled with a one-cycle done pulse. The result is held stable until the next request is accepted.

Parameters:
- None. Data width fixed at 32 bits, amount fixed at 5 bits.

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only when not busy
- in  input  32  operand; latched on accept
- amount  input  5  shift distance 0..31; latched on accept
- op  input  2  operation, latched on accept:
  - 00 = SLL
  - 01 = SRL
  - 11 = SRA
  - 10 = SLL (zero fill)
- busy  output  1  high while in SHIFT state
- done  output  1  one-cycle pulse; result valid
- out  output  32  result; held until next accepted start

Behaviour:
- Reset (synchronous, active-high): on any edge with reset=1, next state is IDLE; busy=0, done=0, out=0, internal count=0.
  - Applies mid-operation: the in-flight request is discarded and done is not pulsed.
  - reset has priority over start on the same edge.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1 for exactly one cycle.
- Accept: start=1 sampled on an edge while state is IDLE or DONE. That edge loads the shift register from in, count from amount, and latches op.
  - amount==0: next state DONE directly; out=in.
  - amount!=0: next state SHIFT.
- SHIFT, each edge: shift register moves one bit, count decrements.
  - Left: fill bit 0.
  - Right: fill bit is in[31] when op==11, else 0.
  - The edge where count==1 performs the final shift, moves to DONE and updates out.
- DONE, next edge:
  - start=1: accepted back-to-back.
  - otherwise: go to IDLE.
- Latency: start sampled at cycle T gives done=1 in cycle T+1+amount, with busy high in cycles T+1..T+amount.
- start in SHIFT state is ignored; no queuing. in, amount and op changes while busy have no effect.
- out changes only on the completing edge or on reset. It is stable in DONE and in the IDLE cycles that follow.
- Results are bit-exact:
  - SLL: in << amount
  - SRL: in >> amount
  - SRA: $signed(in) >>> amount
- Formal build: assert busy and done are never high together. Assert out equals the reference shift of the latched operands whenever done=1.

Optional Feature:
- Macro: SHIFT_SERIAL_NIBBLE_EN
- Defined: each SHIFT edge shifts by 4 bits and subtracts 4 when count>=4; otherwise it shifts by 1 and subtracts 1. The final-step rule becomes "count<=4 with step equal to count, or count==1".
  - Latency: done in cycle T+1+floor(amount/4)+(amount mod 4).
  - amount==0 still completes at T+1.
  - Arithmetic fill is replicated across the 4 vacated bits.
- Undefined: strictly 1 bit per cycle as above. Results are identical in both builds; only latency differs.

Test Plan:
- SLL: in=0x0000_0001, op=00, amount=5, start at T -> busy in T+1..T+5; done and out=0x0000_0020 at T+6 (nibble build: done at T+3).
- SRA: in=0x8000_0000, op=11, amount=31 -> out=0xFFFF_FFFF, done at T+32 (nibble build: T+11). Same input with op=01 -> out=0x0000_0001.
- Zero shift: in=0xDEAD_BEEF, amount=0, op=01 -> done at T+1, out=0xDEAD_BEEF, busy never asserted.
- Overlap: start held high through a 3-bit SRL of 0x0000_0F00 -> intermediate starts ignored; out=0x0000_01E0. A start sampled in the DONE cycle is accepted, so a second request (in=0x1, SLL 1) yields out=0x2 two cycles later.
- Reset mid-shift: SLL amount=20, reset asserted at T+7 -> next cycle busy=0, done=0, out=0; no done pulse for that request. A new request afterwards completes normally.
